// File: rtl/mask_gen_stream.sv
// Streaming row-mask generator: slide, LFSR, tiled and checkerboard modes,
// one row per valid/ready transfer, with a frame-done pulse after the last row.
module mask_gen_stream #(
  parameter int ROW_W   = 640,
  parameter int ROWS    = 480,
  parameter int PAT_MAX = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic [2:0]                   mask_type,
  input  logic [$clog2(PAT_MAX+1)-1:0] pattern_w,
  input  logic                         pattern,
  input  logic                         load_pattern,
  input  logic                         start,
  output logic [0:ROW_W-1]             mask_out,
  output logic                         mask_valid,
  input  logic                         mask_ready,
  output logic [$clog2(ROWS)-1:0]      row_idx,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int          PW_W      = $clog2(PAT_MAX + 1);
  localparam int          PTR_W     = $clog2(PAT_MAX);
  localparam int          IDX_W     = $clog2(ROWS);
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [2:0] {
    M_SLIDE_R = 3'd0,
    M_SLIDE_L = 3'd1,
    M_RAND    = 3'd2,
    M_REPEAT  = 3'd3,
    M_CHECKER = 3'd4
  } mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [PW_W-1:0]    width_q, width_d;
  logic [0:PAT_MAX-1] pat_q, pat_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [0:ROW_W-1]   mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  mode_e              start_mode;
  logic [PW_W-1:0]    start_width;
  logic [31:0]        seed;
  logic               accept;
  logic               last_row;

  // Bit k of the row takes pat[k mod w]; a wrapping counter avoids a divider per bit.
  function automatic logic [0:ROW_W-1] tile_row(input logic [0:PAT_MAX-1] p,
                                                input logic [PW_W-1:0]    w);
    logic [0:ROW_W-1] r;
    logic [PTR_W-1:0] j;
    r = '0;
    j = '0;
    for (int k = 0; k < ROW_W; k++) begin
      r[k] = p[j];
      if (PW_W'(j) == w - 1'b1) j = '0;
      else                      j = j + 1'b1;
    end
    return r;
  endfunction

  function automatic logic [0:ROW_W-1] lfsr_row(input logic [31:0] s);
    logic [0:ROW_W-1] r;
    r = '0;
    for (int k = 0; k < ROW_W; k++) r[k] = s[31 - (k % 32)];
    return r;
  endfunction

  function automatic logic [0:ROW_W-1] slide_base(input logic [0:PAT_MAX-1] p);
    logic [0:ROW_W-1] r;
    r = '0;
    r[0:PAT_MAX-1] = p;
    return r;
  endfunction

  always_comb begin
    start_mode = (mask_type > 3'd4) ? M_REPEAT : mode_e'(mask_type);
    if (pattern_w == '0)                    start_width = PW_W'(1);
    else if (pattern_w > PW_W'(PAT_MAX))    start_width = PW_W'(PAT_MAX);
    else                                    start_width = pattern_w;
    seed     = (pat_q[0:31] == 32'h0) ? 32'h1 : pat_q[0:31];
    accept   = (state_q == RUN) && mask_ready;
    last_row = (idx_q == IDX_W'(ROWS - 1));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    width_d = width_q;
    pat_d   = pat_q;
    ptr_d   = ptr_q;
    lfsr_d  = lfsr_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = start_mode;
          width_d = start_width;
          ptr_d   = '0;
          idx_d   = '0;
          lfsr_d  = seed;
          case (start_mode)
            M_SLIDE_R, M_SLIDE_L: mask_d = slide_base(pat_q);
            M_RAND:               mask_d = lfsr_row(seed);
            default:              mask_d = tile_row(pat_q, start_width);
          endcase
        end else if (load_pattern) begin
          pat_d[ptr_q] = pattern;
          ptr_d = (ptr_q == PTR_W'(PAT_MAX - 1)) ? '0 : ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            case (mode_q)
              M_SLIDE_R: mask_d = {mask_q[ROW_W-1], mask_q[0:ROW_W-2]};
              M_SLIDE_L: mask_d = {mask_q[1:ROW_W-1], mask_q[0]};
              M_RAND: begin
                lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
                mask_d = lfsr_row(lfsr_d);
              end
              M_CHECKER: mask_d = tile_row(pat_q, width_q) ^ {ROW_W{idx_d[0]}};
              default:   mask_d = mask_q;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // clk_en gates every register, so outputs (including frame_done) freeze while low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= M_SLIDE_R;
      width_q <= '0;
      pat_q   <= '0;
      ptr_q   <= '0;
      lfsr_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      width_q <= width_d;
      pat_q   <= pat_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign mask_out   = mask_q;
  assign mask_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign row_idx    = idx_q;
  assign frame_done = done_q;

endmodule

// File: doc/mask_gen_stream.md
# mask_gen_stream

Parametrised successor to the VGA mask generator. It produces one ROW_W-bit mask row per accepted transfer over a valid/ready stream, for ROWS rows per frame. Modes: sliding right, sliding left, LFSR random, tiled repeat, and row-alternating checkerboard. It sits between the host pattern loader (serial bit input) and the row-consumer/display pipeline, and generalises the fixed 640×480 block with downstream back-pressure and a frame-done indication.

## Interface
Parameters:
- ROW_W, 640, bits per row.
- ROWS, 480, rows per frame.
- PAT_MAX, 32, pattern register depth. Legal range 32..64.

Ports:
- clk, in, 1, sole clock.
- rst_n, in, 1, reset. Asynchronous, active-low.
- clk_en, in, 1, global enable. When 0, all state holds and outputs are frozen.
- mask_type, in, 3, mode: 000 slide right, 001 slide left, 010 random, 011 repeat, 100 checker. 101..111 are treated as 011.
- pattern_w, in, $clog2(PAT_MAX+1), tile width for 011/100. 0 is treated as 1; values above PAT_MAX are treated as PAT_MAX.
- pattern, in, 1, serial pattern bit.
- load_pattern, in, 1, writes `pattern` at the current write pointer.
- start, in, 1, begins a frame.
- mask_out, out, [0:ROW_W-1], current row. Index 0 is the leftmost pixel.
- mask_valid, out, 1, mask_out holds a valid row.
- mask_ready, in, 1, consumer accepts the row.
- row_idx, out, $clog2(ROWS), index of the row on mask_out.
- frame_done, out, 1, one-cycle pulse after the last row is accepted.
- busy, out, 1, high while in RUN.

## Operation
- All state updates occur only on clk rising edges with clk_en=1.
- State machine:
  - IDLE→RUN on start=1.
  - RUN→IDLE when the row with row_idx=ROWS-1 is accepted (mask_valid & mask_ready).
  - There is no other transition.
- Pattern load (IDLE only):
  - load_pattern=1 writes pat[ptr] <= pattern, then ptr <= (ptr+1) mod PAT_MAX.
  - pat is not cleared by load; bits not rewritten keep their old values.
  - load_pattern in RUN is ignored.
- On start in IDLE:
  - mask_type and pattern_w are latched, so changes mid-frame have no effect. ptr is cleared.
  - row_idx is set to 0.
  - row 0 is loaded into mask_out and mask_valid is set to 1.
- Row 0 by mode:
  - 000/001: {pat[0:PAT_MAX-1], zeros}.
  - 010: LFSR seed S = pat[0:31], with pat[0] as the MSB. S=0 is replaced by 32'h1. Row bit k = S[31 - (k mod 32)].
  - 011/100: bit k = pat[k mod W], where W is the effective pattern_w.
- On each accepted row that is not the last:
  - row_idx increments by 1.
  - 000: mask_out rotates right by 1; bit k moves to k+1 and bit ROW_W-1 wraps to bit 0.
  - 001: mask_out rotates left by 1.
  - 010: S steps once: S <= S[0] ? (S>>1) ^ 32'h80200003 : S>>1. The row is then re-tiled from the new S.
  - 011: the row is unchanged.
  - 100: the row is the repeat row, inverted when the new row_idx is odd.
- start in RUN is ignored.
- mask_valid & !mask_ready holds mask_out and row_idx stable indefinitely.

## Timing
- Reset values: mask_out=0, mask_valid=0, row_idx=0, frame_done=0, busy=0, pat=0, ptr=0, S=0, state=IDLE.
- Latency from start (cycle N) to row 0 is 1 cycle: mask_valid=1 and busy=1 at N+1.
- Row throughput is 1 row per cycle while mask_ready=1. The next row is on mask_out the cycle after acceptance.
- Acceptance of the last row (cycle M):
  - At M+1: mask_valid=0, busy=0, frame_done=1.
  - At M+2: frame_done=0.
  - mask_out keeps the last row.
- start sampled at M+1 (IDLE) begins a new frame, so back-to-back frames have a 1-cycle bubble.
- load_pattern and start asserted together in IDLE: start wins and the load is dropped.
- clk_en=0 while frame_done=1 extends the pulse until the next enabled edge.
- rst_n low at any time, including mid-frame, forces reset values immediately, with no clock required.

## Test plan
- Slide right: load 32 bits 32'hF0000000 with the first bit = MSB, mask_type=000, mask_ready=1. Required: row 0 = F0000000 followed by 608 zeros; row 1 = 78000000…; row 480 is never emitted; frame_done pulses exactly one cycle after row 479.
- Slide left wrap: pattern 32'h80000000, mask_type=001. Required: row 1 has bit 639 = 1 and all other bits 0; after ROW_W=640 rows (using ROWS=640 in a param override) the row returns to row 0.
- Repeat / checker: pat[0:7]=10110000, pattern_w=3, mask_type=011. Required: every row = "101" repeated, truncated at 640 bits. With 100, odd rows are "010" repeated.
- Random: seed 32'h00000000. Required: S is treated as 1; row 0 bits 0..30 = 0, bit 31 = 1; row 1 S = 32'h80200003. Compare 480 rows against a software model.
- Back-pressure: toggle mask_ready pseudo-randomly. Required: no row is skipped or duplicated, row_idx is strictly sequential, and mask_out is stable while valid & !ready.
- Reset mid-frame: assert rst_n=0 at row 100. Required: all outputs are 0 immediately; a new start after reset gives row 0 from pat=0, i.e. an all-zero row for 000.
